// File: rtl/fpro_bus_pkg.sv
// Shared types and constants for the MCS IO bus to FPro bus bridge.
// Holds the bridge FSM states, error codes and FPro address geometry.
package fpro_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   typedef logic [2:0] err_code_t;

   localparam err_code_t ERR_NONE    = 3'd0;
   localparam err_code_t ERR_OFF_WIN = 3'd1;
   localparam err_code_t ERR_PART_BE = 3'd2;
   localparam err_code_t ERR_RD_WR   = 3'd3;
   localparam err_code_t ERR_OVERRUN = 3'd4;

   localparam int REGION_BIT = 23;
   localparam int FP_AW      = 21;

endpackage

// File: rtl/mcs_io_bus_bridge.sv
// MicroBlaze MCS IO bus to FPro system bus bridge.
// Decodes the window, strobes one FPro slot, returns a one-cycle io_ready.
module mcs_io_bus_bridge
   import fpro_bus_pkg::*;
#(
   parameter logic [31:0] BRG_BASE    = 32'hC000_0000,
   parameter int          RD_WAIT     = 0,
   parameter logic [31:0] ERR_RD_DATA = 32'hDEAD_BEEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             io_addr_strobe,
   input  logic             io_read_strobe,
   input  logic             io_write_strobe,
   input  logic [3:0]       io_byte_enable,
   input  logic [31:0]      io_address,
   input  logic [31:0]      io_write_data,
   output logic [31:0]      io_read_data,
   output logic             io_ready,
   output logic             fp_mmio_cs,
   output logic             fp_video_cs,
   output logic             fp_wr,
   output logic             fp_rd,
   output logic [FP_AW-1:0] fp_addr,
   output logic [31:0]      fp_wr_data,
   input  logic [31:0]      fp_rd_data,
   input  logic             err_clr,
   output logic             err_flag,
   output logic [2:0]       err_code,
   output logic [31:0]      err_addr
);

   localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT - 1);
   localparam logic       HAS_WAIT  = (RD_WAIT != 0);

   state_t state_q, state_d;

   logic [REGION_BIT:2] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        rd_q;
   logic        wr_q;
   logic        legal_q;
   logic [1:0]  cnt_q;

   err_code_t cls_code;
   err_code_t new_code;
   logic      new_err;
   logic      start;
   logic      smp;

   assign start = io_addr_strobe && (state_q == IDLE);

   // First matching rule decides the error reported for a new access
   always_comb begin
      cls_code = ERR_NONE;
      if (io_address[31:24] != BRG_BASE[31:24])
         cls_code = ERR_OFF_WIN;
      else if (io_read_strobe && io_write_strobe)
         cls_code = ERR_RD_WR;
      else if (io_write_strobe && io_byte_enable != 4'hF)
         cls_code = ERR_PART_BE;
   end

   always_comb begin
      new_err  = 1'b0;
      new_code = ERR_NONE;
      if (io_addr_strobe && state_q != IDLE) begin
         new_err  = 1'b1;
         new_code = ERR_OVERRUN;
      end else if (start && cls_code != ERR_NONE) begin
         new_err  = 1'b1;
         new_code = cls_code;
      end
   end

   assign smp = ((state_q == ACCESS) && !(rd_q && HAS_WAIT)) ||
                ((state_q == WAIT) && (cnt_q == WAIT_LAST));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (io_addr_strobe) state_d = ACCESS;
         ACCESS: state_d = (rd_q && HAS_WAIT) ? WAIT : RESP;
         WAIT:   if (cnt_q == WAIT_LAST) state_d = RESP;
         RESP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fp_rd        = 1'b0;
      fp_wr        = 1'b0;
      fp_mmio_cs   = 1'b0;
      fp_video_cs  = 1'b0;
      io_ready     = 1'b0;
      io_read_data = '0;
      unique case (state_q)
         ACCESS: begin
            fp_rd = legal_q && rd_q;
            fp_wr = legal_q && wr_q;
         end
         WAIT: fp_rd = legal_q && rd_q;
         RESP: begin
            io_ready = 1'b1;
            if (rd_q) io_read_data = legal_q ? rdata_q : ERR_RD_DATA;
         end
         default: ;
      endcase
      fp_mmio_cs  = (fp_rd || fp_wr) && !addr_q[REGION_BIT];
      fp_video_cs = (fp_rd || fp_wr) &&  addr_q[REGION_BIT];
   end

   assign fp_addr    = addr_q[REGION_BIT-1:2];
   assign fp_wr_data = wdata_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         legal_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (start) begin
            addr_q  <= io_address[REGION_BIT:2];
            wdata_q <= io_write_data;
            rd_q    <= io_read_strobe;
            wr_q    <= io_write_strobe;
            legal_q <= (cls_code == ERR_NONE);
         end
         if (state_q == ACCESS)    cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_q + 2'd1;
         if (smp && rd_q && legal_q) rdata_q <= fp_rd_data;
      end
   end

   // A clear coinciding with a new error still records that error
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_flag <= 1'b0;
         err_code <= '0;
         err_addr <= '0;
      end else if (new_err && (!err_flag || err_clr)) begin
         err_flag <= 1'b1;
         err_code <= new_code;
         err_addr <= io_address;
      end else if (err_clr) begin
         err_flag <= 1'b0;
         err_code <= '0;
         err_addr <= '0;
      end
   end

endmodule

// File: tb/tb_mcs_io_bus_bridge.sv
// Directed self-checking bench for mcs_io_bus_bridge with RD_WAIT=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mcs_io_bus_bridge;
   import fpro_bus_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        io_addr_strobe;
   logic        io_read_strobe;
   logic        io_write_strobe;
   logic [3:0]  io_byte_enable;
   logic [31:0] io_address;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic        io_ready;
   logic        fp_mmio_cs;
   logic        fp_video_cs;
   logic        fp_wr;
   logic        fp_rd;
   logic [FP_AW-1:0] fp_addr;
   logic [31:0] fp_wr_data;
   logic [31:0] fp_rd_data;
   logic        err_clr;
   logic        err_flag;
   logic [2:0]  err_code;
   logic [31:0] err_addr;

   int checks = 0;
   int errors = 0;

   mcs_io_bus_bridge #(
      .BRG_BASE   (32'hC000_0000),
      .RD_WAIT    (2),
      .ERR_RD_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .io_addr_strobe (io_addr_strobe),
      .io_read_strobe (io_read_strobe),
      .io_write_strobe(io_write_strobe),
      .io_byte_enable (io_byte_enable),
      .io_address     (io_address),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_ready       (io_ready),
      .fp_mmio_cs     (fp_mmio_cs),
      .fp_video_cs    (fp_video_cs),
      .fp_wr          (fp_wr),
      .fp_rd          (fp_rd),
      .fp_addr        (fp_addr),
      .fp_wr_data     (fp_wr_data),
      .fp_rd_data     (fp_rd_data),
      .err_clr        (err_clr),
      .err_flag       (err_flag),
      .err_code       (err_code),
      .err_addr       (err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Present one strobe for one edge; returns in cycle 1 (after the edge)
   task automatic issue(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      io_addr_strobe  = 1'b1;
      io_read_strobe  = rd;
      io_write_strobe = wr;
      io_byte_enable  = be;
      io_address      = addr;
      io_write_data   = data;
      @(negedge clk);
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_byte_enable  = 4'h0;
      io_address      = '0;
      io_write_data   = '0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      reset_n         = 1'b0;
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_byte_enable  = 4'h0;
      io_address      = '0;
      io_write_data   = '0;
      fp_rd_data      = '0;
      err_clr         = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(io_ready), 0);
      chk("rst_rdata", io_read_data, 0);
      chk("rst_wr", 32'(fp_wr), 0);
      chk("rst_rd", 32'(fp_rd), 0);
      chk("rst_addr", 32'(fp_addr), 0);
      chk("rst_flag", 32'(err_flag), 0);
      reset_n = 1'b1;

      // Legal MMIO write
      issue(1'b0, 1'b1, 4'hF, 32'hC000_0104, 32'h1234_5678);
      chk("t1_mmio", 32'(fp_mmio_cs), 1);
      chk("t1_video", 32'(fp_video_cs), 0);
      chk("t1_wr", 32'(fp_wr), 1);
      chk("t1_rd", 32'(fp_rd), 0);
      chk("t1_addr", 32'(fp_addr), 32'h41);
      chk("t1_wdata", fp_wr_data, 32'h1234_5678);
      chk("t1_rdy1", 32'(io_ready), 0);
      @(negedge clk);
      chk("t1_rdy2", 32'(io_ready), 1);
      chk("t1_rdata", io_read_data, 0);
      chk("t1_wr2", 32'(fp_wr), 0);
      chk("t1_addr2", 32'(fp_addr), 32'h41);
      @(negedge clk);
      chk("t1_rdy3", 32'(io_ready), 0);

      // Legal video read, data only valid on the sampling cycle
      fp_rd_data = 32'h1111_1111;
      issue(1'b1, 1'b0, 4'hF, 32'hC080_0008, 32'h0);
      chk("t2_video", 32'(fp_video_cs), 1);
      chk("t2_mmio", 32'(fp_mmio_cs), 0);
      chk("t2_rd1", 32'(fp_rd), 1);
      chk("t2_addr", 32'(fp_addr), 32'h2);
      chk("t2_rdy1", 32'(io_ready), 0);
      @(negedge clk);
      chk("t2_rd2", 32'(fp_rd), 1);
      chk("t2_rdy2", 32'(io_ready), 0);
      @(negedge clk);
      fp_rd_data = 32'hA5A5_0001;
      chk("t2_rd3", 32'(fp_rd), 1);
      chk("t2_rdy3", 32'(io_ready), 0);
      @(negedge clk);
      fp_rd_data = 32'h2222_2222;
      chk("t2_rdy4", 32'(io_ready), 1);
      chk("t2_data", io_read_data, 32'hA5A5_0001);
      chk("t2_rd4", 32'(fp_rd), 0);
      chk("t2_flag", 32'(err_flag), 0);

      // Off-window read
      issue(1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
      chk("t3_rd", 32'(fp_rd), 0);
      chk("t3_cs", 32'(fp_mmio_cs | fp_video_cs), 0);
      chk("t3_flag", 32'(err_flag), 1);
      chk("t3_code", 32'(err_code), 1);
      chk("t3_eaddr", err_addr, 32'h8000_0000);
      @(negedge clk);
      chk("t3_rdy2", 32'(io_ready), 0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_rdy4", 32'(io_ready), 1);
      chk("t3_data", io_read_data, 32'hDEAD_BEEF);

      // Partial-BE write then off-window read
      pulse_clr();
      chk("t4_clr0", 32'(err_flag), 0);
      issue(1'b0, 1'b1, 4'h3, 32'hC000_0010, 32'hCAFE_F00D);
      chk("t4_wr", 32'(fp_wr), 0);
      chk("t4_cs", 32'(fp_mmio_cs | fp_video_cs), 0);
      chk("t4_code", 32'(err_code), 2);
      chk("t4_eaddr", err_addr, 32'hC000_0010);
      @(negedge clk);
      chk("t4_rdy2", 32'(io_ready), 1);
      issue(1'b1, 1'b0, 4'hF, 32'h0100_0000, 32'h0);
      chk("t4_code2", 32'(err_code), 2);
      chk("t4_eaddr2", err_addr, 32'hC000_0010);
      repeat (3) @(negedge clk);
      chk("t4_rdy4", 32'(io_ready), 1);
      pulse_clr();
      chk("t4_flag", 32'(err_flag), 0);
      chk("t4_code3", 32'(err_code), 0);
      chk("t4_eaddr3", err_addr, 0);

      // Read and write together
      issue(1'b1, 1'b1, 4'hF, 32'hC000_0000, 32'h0);
      chk("rw_strobe", 32'(fp_rd | fp_wr), 0);
      chk("rw_code", 32'(err_code), 3);
      repeat (3) @(negedge clk);
      chk("rw_rdy", 32'(io_ready), 1);
      chk("rw_data", io_read_data, 32'hDEAD_BEEF);

      // Clear in the same cycle as a new error: new error wins
      @(negedge clk);
      err_clr         = 1'b1;
      io_addr_strobe  = 1'b1;
      io_write_strobe = 1'b1;
      io_byte_enable  = 4'hF;
      io_address      = 32'h4000_0004;
      @(negedge clk);
      err_clr         = 1'b0;
      io_addr_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_address      = '0;
      chk("cw_flag", 32'(err_flag), 1);
      chk("cw_code", 32'(err_code), 1);
      chk("cw_eaddr", err_addr, 32'h4000_0004);
      @(negedge clk);
      pulse_clr();

      // Overrun during ACCESS
      issue(1'b0, 1'b1, 4'hF, 32'hC000_0020, 32'h0BAD_0001);
      chk("t5_wr1", 32'(fp_wr), 1);
      chk("t5_addr1", 32'(fp_addr), 32'h8);
      io_addr_strobe  = 1'b1;
      io_write_strobe = 1'b1;
      io_byte_enable  = 4'hF;
      io_address      = 32'hC000_0030;
      io_write_data   = 32'h0BAD_0002;
      @(negedge clk);
      io_addr_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_address      = '0;
      io_write_data   = '0;
      chk("t5_rdy2", 32'(io_ready), 1);
      chk("t5_addr2", 32'(fp_addr), 32'h8);
      chk("t5_wdata", fp_wr_data, 32'h0BAD_0001);
      chk("t5_code", 32'(err_code), 4);
      chk("t5_eaddr", err_addr, 32'hC000_0030);
      @(negedge clk);
      chk("t5_rdy3", 32'(io_ready), 0);
      chk("t5_wr3", 32'(fp_wr), 0);
      pulse_clr();

      // Async reset during WAIT
      issue(1'b1, 1'b0, 4'hF, 32'hC000_0040, 32'h0);
      @(negedge clk);
      chk("t6_rd", 32'(fp_rd), 1);
      chk("t6_cs", 32'(fp_mmio_cs), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rd0", 32'(fp_rd), 0);
      chk("t6_cs0", 32'(fp_mmio_cs), 0);
      chk("t6_rdy0", 32'(io_ready), 0);
      repeat (2) begin
         @(negedge clk);
         chk("t6_rdyr", 32'(io_ready), 0);
      end
      reset_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("t6_rdyq", 32'(io_ready), 0);
      end
      issue(1'b0, 1'b1, 4'hF, 32'hC000_0100, 32'h7777_8888);
      chk("t6_wr", 32'(fp_wr), 1);
      chk("t6_addr", 32'(fp_addr), 32'h40);
      @(negedge clk);
      chk("t6_rdy", 32'(io_ready), 1);
      chk("t6_flag", 32'(err_flag), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
